cam_capture: RTL and testbench
==============================

CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter CAM_SCREEN_X, default 256, meaning pixels per captured line.
REQ-002 Parameter CAM_SCREEN_Y, default 256, meaning captured lines per frame.
REQ-003 Parameter AW, default 16, meaning frame-buffer write-address width; AW SHALL satisfy 2^AW >= CAM_SCREEN_X*CAM_SCREEN_Y.
REQ-004 Parameter DW, default 3, meaning stored pixel width (RGB 111).
REQ-005 clk  in  1  system clock; the block SHALL use this single clock, and clk SHALL be at least 4x the cam_pclk frequency.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 cam_pclk  in  1  camera pixel clock, treated as data and sampled in the clk domain.
REQ-008 cam_vsync  in  1  camera frame sync, high between frames.
REQ-009 cam_href  in  1  camera line-valid, high while line bytes are valid.
REQ-010 cam_data  in  8  camera byte, RGB565 with two bytes per pixel, high byte first.
REQ-011 DP_RAM_addr_in  out  AW  frame-buffer write address.
REQ-012 DP_RAM_data_in  out  DW  frame-buffer write data, RGB 111 with R in bit 2.
REQ-013 DP_RAM_regW  out  1  frame-buffer write strobe, one clk wide.
REQ-014 frame_done  out  1  one-clk pulse at the end of a captured frame.

Function
REQ-015 cam_pclk, cam_vsync, cam_href and cam_data SHALL each pass through an identical 2-flop synchronizer, so all four signals arrive with the same delay.
REQ-016 A pclk rise event SHALL be asserted for exactly one clk when the synchronized pclk was 0 in the previous cycle and is 1 in the current cycle.
REQ-017 The block SHALL sample the synchronized href, vsync and data only in cycles where a pclk rise event is asserted.
REQ-018 The FSM SHALL have the states IDLE, WAIT_FRAME, BYTE_HI and BYTE_LO.
REQ-019 IDLE SHALL be the reset state; when synchronized vsync is 1, the FSM SHALL move from IDLE to WAIT_FRAME.
REQ-020 In WAIT_FRAME, a falling edge of synchronized vsync SHALL clear the pixel address to 0 and move the FSM to BYTE_HI.
REQ-021 In BYTE_HI, a pclk rise event with href=1 SHALL latch R=data[7] and G=data[2], then move the FSM to BYTE_LO.
REQ-022 In BYTE_LO, a pclk rise event with href=1 SHALL drive DP_RAM_data_in={R,G,data[4]}, pulse DP_RAM_regW for 1 clk and return the FSM to BYTE_HI.
REQ-023 DP_RAM_regW SHALL be asserted in the cycle immediately after the pclk rise event of the low byte, i.e. 4 clk after cam_pclk rises at the pins.
REQ-024 DP_RAM_addr_in and DP_RAM_data_in SHALL be stable for the entire cycle in which DP_RAM_regW=1.
REQ-025 The pixel address SHALL increment by 1 in the cycle after each write.
REQ-026 When the address equals CAM_SCREEN_X*CAM_SCREEN_Y-1, the address SHALL hold, and further pixels SHALL be dropped (no regW) until the next frame start.
REQ-027 If href falls while the FSM is in BYTE_LO (odd byte count), the orphan byte SHALL be discarded, no write SHALL occur, and the FSM SHALL return to BYTE_HI.
REQ-028 Pixels whose line position is >= CAM_SCREEN_X SHALL be dropped.
REQ-029 The line-position counter SHALL clear on each href falling edge.
REQ-030 A rising edge of synchronized vsync in BYTE_HI or BYTE_LO SHALL pulse frame_done for 1 clk if at least one write occurred in that frame, then move the FSM to WAIT_FRAME.
REQ-031 A vsync rising edge SHALL take priority over a same-cycle byte event, and that byte SHALL be discarded.
REQ-032 The block SHALL never issue a read, and SHALL never assert regW outside BYTE_LO.

Reset
REQ-033 While rst=1, the FSM SHALL be in IDLE and all synchronizer flops SHALL be 0.
REQ-034 While rst=1, DP_RAM_addr_in, DP_RAM_data_in, DP_RAM_regW and frame_done SHALL all be 0.
REQ-035 Reset asserted mid-frame SHALL abort the frame immediately, with no regW and no frame_done pulse.
REQ-036 After reset release, capture SHALL restart only after a complete vsync high-to-low transition.

Verification
REQ-037 Scenario, single pixel: vsync 1->0, then href=1 with bytes 0x84,0x10 -> one regW with addr=0 and data=3'b111, 4 clk after the second pclk rise.
REQ-038 Scenario, full line: 256 pixels of 0xF8,0x00 -> 256 writes with data=3'b100, addresses 0..255, then the address reads 256.
REQ-039 Scenario, odd href: a line of 3 bytes -> exactly 1 write, and the next line starts in BYTE_HI.
REQ-040 Scenario, overflow: 257 lines of 260 pixels -> writes only for line positions 0..255, the address saturates at 65535, and exactly 65536 regW pulses occur.
REQ-041 Scenario, frame end: vsync rises after the last write -> one frame_done pulse; the next vsync fall resets the address to 0.
REQ-042 Scenario, reset mid-line: rst pulse after byte 0x84 -> no regW, outputs 0, FSM in IDLE, capture resumes only after the next vsync fall.

Source files
------------

// File: rtl/cam_capture.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cam_capture: RGB565 camera byte stream to RGB111 frame-buffer writes
// Revision 1.0
// ----------------------------------------------------------------------------
module cam_capture #(
  parameter int CAM_SCREEN_X = 256,
  parameter int CAM_SCREEN_Y = 256,
  parameter int AW           = 16,
  parameter int DW           = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cam_pclk,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic [7:0]    cam_data,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic          DP_RAM_regW,
  output logic          frame_done
);

  localparam int            CW       = $clog2(CAM_SCREEN_X + 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(CAM_SCREEN_X);
  localparam logic [AW-1:0] ADDR_MAX = AW'(CAM_SCREEN_X * CAM_SCREEN_Y - 1);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_WAIT_FRAME = 2'd1;
  localparam logic [1:0] S_BYTE_HI    = 2'd2;
  localparam logic [1:0] S_BYTE_LO    = 2'd3;

  logic [10:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic          pclk_prev_q, pclk_prev_d;
  logic          rise_q, rise_d;
  logic [9:0]    smp_q, smp_d;
  logic [1:0]    state_q, state_d;
  logic          vs_prev_q, vs_prev_d;
  logic          hr_prev_q, hr_prev_d;
  logic          r_q, r_d, g_q, g_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          regw_q, regw_d;
  logic          done_q, done_d;
  logic          wrote_q, wrote_d;
  logic          full_q, full_d;

  logic vs, hr;
  logic unused_bits;

  // The rise event and the sampled bus travel through one extra stage together,
  // so href/vsync/data seen on a rise always belong to that pclk edge.
  assign vs          = smp_q[9];
  assign hr          = smp_q[8];
  assign unused_bits = ^{smp_q[6:5], smp_q[3], smp_q[1:0]};

  always_comb begin
    sync1_d     = {cam_pclk, cam_vsync, cam_href, cam_data};
    sync2_d     = sync1_q;
    pclk_prev_d = sync2_q[10];
    rise_d      = sync2_q[10] & ~pclk_prev_q;
    smp_d       = sync2_q[9:0];

    state_d   = state_q;
    vs_prev_d = vs_prev_q;
    hr_prev_d = hr_prev_q;
    r_d       = r_q;
    g_d       = g_q;
    col_d     = col_q;
    addr_d    = addr_q;
    data_d    = data_q;
    regw_d    = 1'b0;
    done_d    = 1'b0;
    wrote_d   = wrote_q;
    full_d    = full_q;

    // Address advances after the write it belonged to; the last slot latches full.
    if (regw_q) begin
      if (addr_q == ADDR_MAX) full_d = 1'b1;
      else                    addr_d = addr_q + AW'(1);
    end

    if (rise_q) begin
      vs_prev_d = vs;
      hr_prev_d = hr;
      if (hr_prev_q && !hr) col_d = '0;
      case (state_q)
        S_IDLE: begin
          if (vs) state_d = S_WAIT_FRAME;
        end
        S_WAIT_FRAME: begin
          if (vs_prev_q && !vs) begin
            addr_d  = '0;
            col_d   = '0;
            full_d  = 1'b0;
            wrote_d = 1'b0;
            state_d = S_BYTE_HI;
          end
        end
        default: begin
          if (vs && !vs_prev_q) begin
            done_d  = wrote_q;
            state_d = S_WAIT_FRAME;
          end else if (!hr) begin
            state_d = S_BYTE_HI;
          end else if (state_q == S_BYTE_HI) begin
            r_d     = smp_q[7];
            g_d     = smp_q[2];
            state_d = S_BYTE_LO;
          end else begin
            state_d = S_BYTE_HI;
            if (col_q < COL_MAX) begin
              col_d = col_q + CW'(1);
              if (!full_q) begin
                regw_d  = 1'b1;
                data_d  = DW'({r_q, g_q, smp_q[4]});
                wrote_d = 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      pclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      smp_q       <= '0;
      state_q     <= S_IDLE;
      vs_prev_q   <= 1'b0;
      hr_prev_q   <= 1'b0;
      r_q         <= 1'b0;
      g_q         <= 1'b0;
      col_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      regw_q      <= 1'b0;
      done_q      <= 1'b0;
      wrote_q     <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      pclk_prev_q <= pclk_prev_d;
      rise_q      <= rise_d;
      smp_q       <= smp_d;
      state_q     <= state_d;
      vs_prev_q   <= vs_prev_d;
      hr_prev_q   <= hr_prev_d;
      r_q         <= r_d;
      g_q         <= g_d;
      col_q       <= col_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      regw_q      <= regw_d;
      done_q      <= done_d;
      wrote_q     <= wrote_d;
      full_q      <= full_d;
    end
  end

  assign DP_RAM_addr_in = addr_q;
  assign DP_RAM_data_in = data_q;
  assign DP_RAM_regW    = regw_q;
  assign frame_done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_capture.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cam_capture: scoreboard bench for cam_capture on a reduced 16x4 frame
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_cam_capture;
  localparam int X    = 16;
  localparam int Y    = 4;
  localparam int AW   = 6;
  localparam int DW   = 3;
  localparam int MAXA = X * Y - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cam_pclk = 1'b0;
  logic          cam_vsync = 1'b0;
  logic          cam_href = 1'b0;
  logic [7:0]    cam_data = 8'h00;
  logic [AW-1:0] DP_RAM_addr_in;
  logic [DW-1:0] DP_RAM_data_in;
  logic          DP_RAM_regW;
  logic          frame_done;

  cam_capture #(.CAM_SCREEN_X(X), .CAM_SCREEN_Y(Y), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .DP_RAM_addr_in(DP_RAM_addr_in),
    .DP_RAM_data_in(DP_RAM_data_in), .DP_RAM_regW(DP_RAM_regW), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0, n_fail = 0;
  int n_writes = 0, n_done = 0, last_wr_cyc = 0, rise_cyc = 0;
  int maddr = 0, mcol = 0;
  bit mfull = 1'b0;
  logic [AW+DW-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every write strobe must match the oldest expected {addr,data}
  always @(posedge clk) begin
    logic [AW+DW-1:0] e;
    #1;
    if (DP_RAM_regW === 1'b1) begin
      n_writes++;
      last_wr_cyc = cyc;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_write: got addr=%0d data=%b, required no write", DP_RAM_addr_in, DP_RAM_data_in);
      end else begin
        e = exp_q.pop_front();
        if ({DP_RAM_addr_in, DP_RAM_data_in} !== e)
          begin n_fail++; $display("FAIL sb_write: got addr=%0d data=%b, required addr=%0d data=%b",
                                   DP_RAM_addr_in, DP_RAM_data_in, e[AW+DW-1:DW], e[DW-1:0]); end
      end
    end
    if (frame_done === 1'b1) n_done++;
  end

  task automatic send_byte(input logic [7:0] b, input logic h);
    cam_data = b; cam_href = h; cam_pclk = 1'b0;
    repeat (2) @(negedge clk);
    cam_pclk = 1'b1; rise_cyc = cyc;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo);
    logic [AW-1:0] a;
    a = maddr[AW-1:0];
    if (mcol < X && !mfull) begin
      exp_q.push_back({a, hi[7], hi[2], lo[4]});
      if (maddr == MAXA) mfull = 1'b1; else maddr++;
    end
    mcol++;
    send_byte(hi, 1'b1);
    send_byte(lo, 1'b1);
  endtask

  task automatic end_line();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    mcol = 0;
  endtask

  task automatic frame_start();
    cam_vsync = 1'b1;
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    cam_vsync = 1'b0;
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    maddr = 0; mcol = 0; mfull = 1'b0;
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1;
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
  endtask

  task automatic settle();
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++; if (DP_RAM_addr_in !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d, required 0", DP_RAM_addr_in); end
    n_checks++; if (DP_RAM_data_in !== '0) begin n_fail++; $display("FAIL reset_data: got %b, required 000", DP_RAM_data_in); end
    n_checks++; if (DP_RAM_regW !== 1'b0) begin n_fail++; $display("FAIL reset_regw: got %b, required 0", DP_RAM_regW); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", frame_done); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_pixel();
    int w0, lo_rise;
    w0 = n_writes;
    frame_start();
    send_pixel(8'h84, 8'h10);
    lo_rise = rise_cyc;
    end_line();
    settle();
    n_checks++; if (n_writes - w0 != 1) begin n_fail++; $display("FAIL single_count: got %0d writes, required 1", n_writes - w0); end
    n_checks++; if (last_wr_cyc - lo_rise != 4) begin n_fail++; $display("FAIL single_latency: got %0d clk, required 4", last_wr_cyc - lo_rise); end
    n_checks++; if (DP_RAM_addr_in !== AW'(1)) begin n_fail++; $display("FAIL single_addr_after: got %0d, required 1", DP_RAM_addr_in); end
  endtask

  task automatic test_full_line();
    int w0;
    w0 = n_writes;
    frame_start();
    for (int p = 0; p < X; p++) send_pixel(8'hF8, 8'h00);
    end_line();
    settle();
    n_checks++; if (n_writes - w0 != X) begin n_fail++; $display("FAIL line_count: got %0d writes, required %0d", n_writes - w0, X); end
    n_checks++; if (DP_RAM_addr_in !== AW'(X)) begin n_fail++; $display("FAIL line_addr_after: got %0d, required %0d", DP_RAM_addr_in, X); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL line_pending: got %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_odd_href();
    int w0;
    w0 = n_writes;
    send_pixel(8'h84, 8'h10);
    send_byte(8'hFF, 1'b1);
    end_line();
    send_pixel(8'h00, 8'h10);
    end_line();
    settle();
    n_checks++; if (n_writes - w0 != 2) begin n_fail++; $display("FAIL odd_count: got %0d writes, required 2", n_writes - w0); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL odd_pending: got %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_frame_end();
    int d0;
    d0 = n_done;
    frame_end();
    settle();
    n_checks++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL end_done: got %0d pulses, required 1", n_done - d0); end
    frame_start();
    settle();
    n_checks++; if (DP_RAM_addr_in !== '0) begin n_fail++; $display("FAIL end_addr_reset: got %0d, required 0", DP_RAM_addr_in); end
    frame_end();
    settle();
    n_checks++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL end_empty_frame: got %0d pulses, required 1", n_done - d0); end
  endtask

  task automatic test_vsync_priority();
    int w0, d0;
    w0 = n_writes; d0 = n_done;
    frame_start();
    send_pixel(8'hF8, 8'h00);
    send_byte(8'h84, 1'b1);
    cam_vsync = 1'b1;
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b0);
    settle();
    n_checks++; if (n_writes - w0 != 1) begin n_fail++; $display("FAIL prio_count: got %0d writes, required 1", n_writes - w0); end
    n_checks++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL prio_done: got %0d pulses, required 1", n_done - d0); end
  endtask

  task automatic test_overflow();
    int w0, d0;
    logic [7:0] hi, lo;
    w0 = n_writes;
    frame_start();
    for (int l = 0; l <= Y; l++) begin
      for (int p = 0; p < X + 4; p++) begin
        hi = 8'($urandom); lo = 8'($urandom);
        send_pixel(hi, lo);
      end
      end_line();
    end
    settle();
    n_checks++; if (n_writes - w0 != X * Y) begin n_fail++; $display("FAIL ovf_count: got %0d writes, required %0d", n_writes - w0, X * Y); end
    n_checks++; if (DP_RAM_addr_in !== AW'(MAXA)) begin n_fail++; $display("FAIL ovf_addr: got %0d, required %0d", DP_RAM_addr_in, MAXA); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ovf_pending: got %0d outstanding, required 0", exp_q.size()); end
    d0 = n_done;
    frame_end();
    settle();
    n_checks++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL ovf_done: got %0d pulses, required 1", n_done - d0); end
  endtask

  task automatic test_reset_midline();
    int w0, d0;
    w0 = n_writes; d0 = n_done;
    frame_start();
    send_byte(8'h84, 1'b1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (DP_RAM_addr_in !== '0) begin n_fail++; $display("FAIL rst_mid_addr: got %0d, required 0", DP_RAM_addr_in); end
    n_checks++; if (DP_RAM_data_in !== '0) begin n_fail++; $display("FAIL rst_mid_data: got %b, required 000", DP_RAM_data_in); end
    n_checks++; if (DP_RAM_regW !== 1'b0) begin n_fail++; $display("FAIL rst_mid_regw: got %b, required 0", DP_RAM_regW); end
    rst = 1'b0;
    send_byte(8'h10, 1'b1);
    send_byte(8'h84, 1'b1);
    send_byte(8'h10, 1'b1);
    end_line();
    settle();
    n_checks++; if (n_writes - w0 != 0) begin n_fail++; $display("FAIL rst_mid_nowrite: got %0d writes, required 0", n_writes - w0); end
    n_checks++; if (n_done - d0 != 0) begin n_fail++; $display("FAIL rst_mid_nodone: got %0d pulses, required 0", n_done - d0); end
    frame_start();
    send_pixel(8'h84, 8'h10);
    end_line();
    settle();
    n_checks++; if (n_writes - w0 != 1) begin n_fail++; $display("FAIL rst_mid_resume: got %0d writes, required 1", n_writes - w0); end
    n_checks++; if (DP_RAM_addr_in !== AW'(1)) begin n_fail++; $display("FAIL rst_mid_addr_after: got %0d, required 1", DP_RAM_addr_in); end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_full_line();
    test_odd_href();
    test_frame_end();
    test_vsync_priority();
    test_overflow();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
